// File: rtl/serial_secded_decoder.sv
// Serial extended-Hamming (SEC-DED) decoder.
// Bits arrive one per strobe, position 0 (overall parity) first. A complete
// codeword is captured, its syndrome and overall parity are registered, and the
// classified word is then presented on a one-entry valid/ack output buffer.
// Saturating counters track corrected and uncorrectable words.
module serial_secded_decoder #(
    parameter int DATA_W = 4,
    parameter int PAR_W  = 3,
    parameter int CNT_W  = 8
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              DDATA,
    input  logic              DSTROBE,
    input  logic              FLUSH,
    input  logic              MODE,
    output logic [DATA_W-1:0] DOUT,
    output logic              DREADY,
    input  logic              DACK,
    output logic              DCORR,
    output logic              DERROR,
    output logic              OVERFLOW,
    output logic [CNT_W-1:0]  CORR_CNT,
    output logic [CNT_W-1:0]  UNC_CNT
);

    localparam int CODE_W = DATA_W + PAR_W + 1;
    localparam int IDX_W  = $clog2(CODE_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CODE_W - 1);
    localparam logic [PAR_W-1:0] MAX_POS  = PAR_W'(CODE_W - 1);

    // The Hamming positions 1..CODE_W-1 must all be addressable by the syndrome.
    generate
        if ((2 ** PAR_W) < (DATA_W + PAR_W + 1)) begin : g_bad_par_w
            $error("serial_secded_decoder: PAR_W too small for DATA_W");
        end
    endgenerate

    // Codeword position that carries data bit k: the k-th position in 1..CODE_W-1
    // that is not a power of two.
    function automatic int data_pos(input int k);
        int n;
        int res;
        n   = 0;
        res = 0;
        for (int p = 1; p < CODE_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == k) begin
                    res = p;
                end
                n = n + 1;
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Stage 1: deserialiser and capture register
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CODE_W-1:0] acc_q, acc_d;
    logic [CODE_W-1:0] cap_q;
    logic              cap_vld_q;
    logic              last_bit;

    // FLUSH has priority over the strobe, so a bit presented with FLUSH is lost.
    assign last_bit = DSTROBE && !FLUSH && (bit_cnt_q == LAST_IDX);

    // Next accumulator contents and bit position for this cycle's input bit.
    always_comb begin
        acc_d     = acc_q;
        bit_cnt_d = bit_cnt_q;
        if (FLUSH) begin
            bit_cnt_d = '0;
        end else if (DSTROBE) begin
            acc_d[bit_cnt_q] = DDATA;
            bit_cnt_d        = last_bit ? '0 : bit_cnt_q + IDX_W'(1);
        end
    end

    // Accumulate bits and latch the whole codeword on its final bit.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            bit_cnt_q <= '0;
            acc_q     <= '0;
            cap_q     <= '0;
            cap_vld_q <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            acc_q     <= acc_d;
            cap_vld_q <= last_bit;
            if (last_bit) begin
                cap_q <= acc_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2a: syndrome / overall parity register
    // ------------------------------------------------------------------
    logic [PAR_W-1:0]  syn_d, syn_q;
    logic              par_d, par_q;
    logic [DATA_W-1:0] raw_data_d, raw_data_q;
    logic              word_vld_q;

    // Syndrome is the XOR of the indices of every set bit in positions 1..CODE_W-1.
    always_comb begin
        syn_d = '0;
        for (int p = 1; p < CODE_W; p++) begin
            if (cap_q[p]) begin
                syn_d = syn_d ^ PAR_W'(p);
            end
        end
        par_d = ^cap_q;
    end

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_raw_data
            localparam int POS = data_pos(gi);
            assign raw_data_d[gi] = cap_q[POS];
        end
    endgenerate

    // Register syndrome, parity and the uncorrected data field.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            syn_q      <= '0;
            par_q      <= 1'b0;
            raw_data_q <= '0;
            word_vld_q <= 1'b0;
        end else begin
            word_vld_q <= cap_vld_q;
            if (cap_vld_q) begin
                syn_q      <= syn_d;
                par_q      <= par_d;
                raw_data_q <= raw_data_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2b: classification, correction and output buffer
    // ------------------------------------------------------------------
    logic              syn_nz, in_range, corr_flag, err_flag, flip_en;
    logic [DATA_W-1:0] fixed_data;

    assign syn_nz    = |syn_q;
    assign in_range  = (syn_q <= MAX_POS);
    // Single error: either a located bit, or the overall parity bit itself.
    assign corr_flag = par_q && (!syn_nz || in_range);
    // Double error (even parity, nonzero syndrome) or a syndrome naming no bit.
    assign err_flag  = syn_nz && (!par_q || !in_range);
    // Detect-only mode never alters data.
    assign flip_en   = !MODE && par_q && syn_nz && in_range;

    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_fix_data
            localparam int POS = data_pos(gi);
            assign fixed_data[gi] = raw_data_q[gi] ^ (flip_en && (syn_q == PAR_W'(POS)));
        end
    endgenerate

    logic [DATA_W-1:0] dout_q;
    logic              dready_q, dcorr_q, derror_q, ovf_q;
    logic [CNT_W-1:0]  corr_cnt_q, unc_cnt_q;

    // Load a new word into the buffer when it is free or being acked; else drop it.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            dout_q   <= '0;
            dready_q <= 1'b0;
            dcorr_q  <= 1'b0;
            derror_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (word_vld_q) begin
            if (!dready_q || DACK) begin
                dout_q   <= fixed_data;
                dready_q <= 1'b1;
                dcorr_q  <= corr_flag;
                derror_q <= err_flag;
            end else begin
                ovf_q <= 1'b1;
            end
        end else if (DACK) begin
            dready_q <= 1'b0;
        end
    end

    // Saturating statistics; dropped words are still counted.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            corr_cnt_q <= '0;
            unc_cnt_q  <= '0;
        end else if (word_vld_q) begin
            if (corr_flag && (corr_cnt_q != '1)) begin
                corr_cnt_q <= corr_cnt_q + CNT_W'(1);
            end
            if (err_flag && (unc_cnt_q != '1)) begin
                unc_cnt_q <= unc_cnt_q + CNT_W'(1);
            end
        end
    end

    assign DOUT     = dout_q;
    assign DREADY   = dready_q;
    assign DCORR    = dcorr_q;
    assign DERROR   = derror_q;
    assign OVERFLOW = ovf_q;
    assign CORR_CNT = corr_cnt_q;
    assign UNC_CNT  = unc_cnt_q;

endmodule

// File: tb/tb_serial_secded_decoder.sv
// Self-checking bench for serial_secded_decoder: table-driven vectors,
// hand-written corner sequences, and randomized traffic checked every cycle
// against a word-level reference model (queue of pending codewords).
module tb_serial_secded_decoder;

    localparam int DW = 4;
    localparam int PW = 3;
    localparam int CW = DW + PW + 1;

    logic          CLOCK = 1'b0;
    logic          RESET, DDATA, DSTROBE, FLUSH, MODE, DACK;
    logic [DW-1:0] DOUT;
    logic          DREADY, DCORR, DERROR, OVERFLOW;
    logic [7:0]    CORR_CNT, UNC_CNT;

    logic [DW-1:0] s_dout;
    logic          s_dready, s_dcorr, s_derror, s_ovf;
    logic [1:0]    s_corr_cnt, s_unc_cnt;

    always #5 CLOCK = ~CLOCK;

    serial_secded_decoder #(.DATA_W(DW), .PAR_W(PW), .CNT_W(8)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .DDATA(DDATA), .DSTROBE(DSTROBE),
        .FLUSH(FLUSH), .MODE(MODE), .DOUT(DOUT), .DREADY(DREADY), .DACK(DACK),
        .DCORR(DCORR), .DERROR(DERROR), .OVERFLOW(OVERFLOW),
        .CORR_CNT(CORR_CNT), .UNC_CNT(UNC_CNT)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    serial_secded_decoder #(.DATA_W(DW), .PAR_W(PW), .CNT_W(2)) dut_sat (
        .CLOCK(CLOCK), .RESET(RESET), .DDATA(DDATA), .DSTROBE(DSTROBE),
        .FLUSH(FLUSH), .MODE(MODE), .DOUT(s_dout), .DREADY(s_dready), .DACK(DACK),
        .DCORR(s_dcorr), .DERROR(s_derror), .OVERFLOW(s_ovf),
        .CORR_CNT(s_corr_cnt), .UNC_CNT(s_unc_cnt)
    );

    typedef struct {
        logic [CW-1:0] cw;
        int            due;
    } pend_t;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          corr;
        logic          err;
    } res_t;

    typedef struct {
        logic [CW-1:0] cw;
        logic          mode;
        logic [DW-1:0] dout;
        logic          corr;
        logic          err;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    pend_t         pq[$];
    int            m_idx;
    logic [CW-1:0] m_buf;
    logic          m_ready, m_corr, m_err, m_ovf;
    logic [DW-1:0] m_dout;
    int            m_cc, m_uc;

    function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
        logic [CW-1:0] c;
        logic          b;
        int            k;
        c = '0;
        k = 0;
        for (int p = 1; p < CW; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p] = d[k];
                k++;
            end
        end
        for (int j = 0; j < PW; j++) begin
            b = 1'b0;
            for (int p = 1; p < CW; p++) begin
                if (((p >> j) & 1) == 1 && p != (1 << j)) b = b ^ c[p];
            end
            c[1 << j] = b;
        end
        c[0] = ^c;
        return c;
    endfunction

    function automatic res_t decode(input logic [CW-1:0] cw_in, input logic mode);
        logic [CW-1:0] c;
        int            s;
        int            k;
        logic          par;
        res_t          r;
        c = cw_in;
        s = 0;
        for (int p = 1; p < CW; p++) if (c[p]) s = s ^ p;
        par    = ^c;
        r.corr = 1'b0;
        r.err  = 1'b0;
        if (par) begin
            if (s == 0) begin
                r.corr = 1'b1;
            end else if (s <= CW - 1) begin
                r.corr = 1'b1;
                if (!mode) c[s] = ~c[s];
            end else begin
                r.err = 1'b1;
            end
        end else if (s != 0) begin
            r.err = 1'b1;
        end
        r.d = '0;
        k   = 0;
        for (int p = 1; p < CW; p++) begin
            if ((p & (p - 1)) != 0) begin
                r.d[k] = c[p];
                k++;
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    // amode: 0 = DACK low, 1 = DACK high, 2 = DACK pulsed only on word-load edges.
    task automatic cycle(input logic d, input logic s, input logic f,
                         input int amode, input logic m, input logic r);
        logic  a;
        res_t  res;
        pend_t pe;
        logic  load_now;
        load_now = 1'b0;
        if (pq.size() > 0) load_now = (pq[0].due == cyc);
        a = (amode == 2) ? load_now : (amode == 1);
        DDATA = d; DSTROBE = s; FLUSH = f; DACK = a; MODE = m; RESET = r;
        if (r) begin
            pq.delete();
            m_idx = 0; m_buf = '0; m_ready = 0; m_dout = '0;
            m_corr = 0; m_err = 0; m_ovf = 0; m_cc = 0; m_uc = 0;
        end else begin
            if (load_now) begin
                pe  = pq.pop_front();
                res = decode(pe.cw, m);
                if (!m_ready || a) begin
                    m_ready = 1; m_dout = res.d; m_corr = res.corr; m_err = res.err;
                end else begin
                    m_ovf = 1;
                end
                if (res.corr && m_cc < 255) m_cc++;
                if (res.err && m_uc < 255) m_uc++;
            end else if (a) begin
                m_ready = 0;
            end
            if (f) begin
                m_idx = 0;
            end else if (s) begin
                m_buf[m_idx] = d;
                if (m_idx == CW - 1) begin
                    pe.cw  = m_buf;
                    pe.due = cyc + 2;
                    pq.push_back(pe);
                    m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
        end
        @(posedge CLOCK);
        cyc++;
        @(negedge CLOCK);
        check("DREADY", DREADY, m_ready);
        check("DOUT", DOUT, m_dout);
        check("DCORR", DCORR, m_corr);
        check("DERROR", DERROR, m_err);
        check("OVERFLOW", OVERFLOW, m_ovf);
        check("CORR_CNT", CORR_CNT, m_cc);
        check("UNC_CNT", UNC_CNT, m_uc);
        check("SAT_CORR_CNT", s_corr_cnt, (m_cc > 3) ? 3 : m_cc);
        check("SAT_UNC_CNT", s_unc_cnt, (m_uc > 3) ? 3 : m_uc);
    endtask

    task automatic send_word(input logic [CW-1:0] cw, input logic m, input int amode, input int gap);
        for (int i = 0; i < CW; i++) cycle(cw[i], 1'b1, 1'b0, amode, m, 1'b0);
        for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, 1'b0, amode, m, 1'b0);
    endtask

    vec_t tbl[10];

    initial begin
        logic [CW-1:0] rcw;
        logic          rm;
        int            ra;

        tbl[0] = '{8'hFF, 1'b0, 4'hF, 1'b0, 1'b0};
        tbl[1] = '{8'hDF, 1'b0, 4'hF, 1'b1, 1'b0};
        tbl[2] = '{8'hDF, 1'b1, 4'hD, 1'b1, 1'b0};
        tbl[3] = '{8'hD7, 1'b0, 4'hC, 1'b0, 1'b1};
        tbl[4] = '{8'hFE, 1'b0, 4'hF, 1'b1, 1'b0};
        tbl[5] = '{8'hFE, 1'b1, 4'hF, 1'b1, 1'b0};
        tbl[6] = '{8'h00, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[7] = '{8'h80, 1'b0, 4'h0, 1'b1, 1'b0};
        tbl[8] = '{8'h80, 1'b1, 4'h8, 1'b1, 1'b0};
        tbl[9] = '{8'h06, 1'b0, 4'h0, 1'b0, 1'b1};

        DDATA = 0; DSTROBE = 0; FLUSH = 0; MODE = 0; DACK = 0; RESET = 1;

        // Reset state
        cycle(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        check("rst_dready", DREADY, 0);
        check("rst_dout", DOUT, 0);
        check("rst_cnt", {CORR_CNT, UNC_CNT}, 0);

        // Latency: last bit at edge t, DREADY only after edge t+2
        send_word(8'hFF, 1'b0, 1, 1);
        check("lat_t1_dready", DREADY, 0);
        cycle(1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        check("lat_t2_dready", DREADY, 1);
        check("lat_t2_dout", DOUT, 4'hF);

        // Table-driven vectors, each acked
        for (int i = 0; i < 10; i++) begin
            send_word(tbl[i].cw, tbl[i].mode, 1, 2);
            check("tbl_dready", DREADY, 1);
            check("tbl_dout", DOUT, tbl[i].dout);
            check("tbl_dcorr", DCORR, tbl[i].corr);
            check("tbl_derror", DERROR, tbl[i].err);
        end

        // Three back-to-back zero words, no ack: first held, others dropped
        cycle(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        send_word(8'h00, 1'b0, 0, 0);
        send_word(8'h00, 1'b0, 0, 0);
        send_word(8'h00, 1'b0, 0, 3);
        check("ovf_set", OVERFLOW, 1);
        check("ovf_dready", DREADY, 1);
        check("ovf_dout", DOUT, 0);

        // Same run with DACK pulsed on each load edge: never overflows
        cycle(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        send_word(8'h00, 1'b0, 2, 0);
        send_word(8'hFF, 1'b0, 2, 0);
        send_word(8'h00, 1'b0, 2, 3);
        check("ackpulse_ovf", OVERFLOW, 0);
        check("ackpulse_dready", DREADY, 1);
        check("ackpulse_dout", DOUT, 0);

        // FLUSH after 5 bits, and FLUSH beating a simultaneous strobe
        cycle(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        send_word(8'hFF, 1'b0, 0, 12);
        check("flush_dready", DREADY, 1);
        check("flush_dout", DOUT, 4'hF);
        check("flush_clean", {DCORR, DERROR, OVERFLOW}, 0);

        // RESET mid-word discards partial bits
        cycle(1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1);
        check("midrst_dready", DREADY, 0);
        check("midrst_cnt", CORR_CNT, 0);
        send_word(8'h0F, 1'b0, 0, 2);
        check("midrst_dout", DOUT, 4'h1);
        check("midrst_flags", {DREADY, DCORR, DERROR}, 3'b100);

        // Counter saturation on the 2-bit instance
        cycle(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) send_word(8'hDF, 1'b0, 1, 2);
        check("sat_corr_cnt", s_corr_cnt, 3);
        check("wide_corr_cnt", CORR_CNT, 5);

        // Randomized traffic checked against the model every cycle
        cycle(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        for (int w = 0; w < 300; w++) begin
            rcw = encode(4'($urandom));
            for (int e = $urandom_range(0, 3); e > 0; e--) begin
                rcw[$urandom_range(0, CW - 1)] ^= 1'b1;
            end
            rm = 1'($urandom_range(0, 1));
            for (int i = 0; i < CW; i++) begin
                ra = ($urandom_range(0, 3) != 0) ? 1 : 0;
                if ($urandom_range(0, 199) == 0)
                    cycle(1'b0, 1'($urandom_range(0, 1)), 1'b1, ra, rm, 1'b0);
                if ($urandom_range(0, 3) == 0)
                    cycle(1'b0, 1'b0, 1'b0, ra, rm, 1'b0);
                cycle(rcw[i], 1'b1, 1'b0, ra, rm, 1'b0);
            end
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
